// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - state and owner codes for the shared memory port arbiter
package mem_port_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ARB_IDLE = 2'd0;
  localparam arb_state_t ARB_REQ  = 2'd1;
  localparam arb_state_t ARB_WAIT = 2'd2;

  localparam logic ARB_OWN_IF  = 1'b0;
  localparam logic ARB_OWN_MEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one SRAM-like port between fetch and load/store, one transaction in flight
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state;
  logic             owner;
  logic [CNT_W-1:0] starve_cnt;

  logic             grant;
  logic             grant_owner;
  logic [CNT_W-1:0] starve_nxt;

  // A data grant with inst pending only happens below CNT_MAX, so the increment saturates by construction.
  always_comb begin
    grant       = 1'b0;
    grant_owner = ARB_OWN_IF;
    starve_nxt  = starve_cnt;
    if (data_req && !(inst_req && starve_cnt == CNT_MAX)) begin
      grant       = 1'b1;
      grant_owner = ARB_OWN_MEM;
      if (inst_req) starve_nxt = starve_cnt + CNT_ONE;
    end else if (inst_req) begin
      grant       = 1'b1;
      grant_owner = ARB_OWN_IF;
      starve_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ARB_IDLE;
      owner      <= ARB_OWN_IF;
      starve_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: if (grant) begin
          state      <= ARB_REQ;
          owner      <= grant_owner;
          starve_cnt <= starve_nxt;
        end
        ARB_REQ:  if (mem_addr_ok) state <= ARB_WAIT;
        ARB_WAIT: if (mem_data_ok) state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  logic in_req;
  logic in_wait;
  logic own_mem;

  assign in_req  = (state == ARB_REQ);
  assign in_wait = (state == ARB_WAIT);
  assign own_mem = (owner == ARB_OWN_MEM);

  assign mem_req   = in_req;
  assign mem_wr    = own_mem & data_wr;
  assign mem_wstrb = (own_mem && data_wr) ? data_wstrb : '0;
  assign mem_addr  = own_mem ? data_addr : inst_addr;
  assign mem_wdata = own_mem ? data_wdata : '0;

  // Handshake pulses outside their own state are protocol violations and are dropped here.
  assign inst_addr_ok = in_req & mem_addr_ok & ~own_mem;
  assign data_addr_ok = in_req & mem_addr_ok & own_mem;
  assign inst_data_ok = in_wait & mem_data_ok & ~own_mem;
  assign data_data_ok = in_wait & mem_data_ok & own_mem;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;
  int starve_m = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit predict_data();
    return data_req && !(inst_req && starve_m == LIMIT);
  endfunction

  task automatic rand_data();
    data_wr    = 1'($urandom_range(0, 1));
    data_wstrb = data_wr ? 4'($urandom_range(1, 15)) : 4'h0;
    data_addr  = $urandom & 32'hffff_fffc;
    data_wdata = $urandom;
  endtask

  task automatic rand_inst();
    inst_addr = $urandom & 32'hffff_fffc;
  endtask

  // Runs one transaction from an IDLE negedge: grant, address phase with alat stall cycles, data phase.
  task automatic serve(input bit exp_data, input int alat, input int dlat, input logic [31:0] rdata);
    int          wait_n;
    logic        e_wr;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_wdata;
    if (exp_data) begin
      if (inst_req && starve_m < LIMIT) starve_m++;
    end else begin
      starve_m = 0;
    end
    e_wr    = exp_data ? data_wr : 1'b0;
    e_strb  = (exp_data && data_wr) ? data_wstrb : 4'h0;
    e_addr  = exp_data ? data_addr : inst_addr;
    e_wdata = exp_data ? data_wdata : 32'h0;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (mem_req !== 1'b1 && wait_n < 8);
    chk("grant_latency", 64'(wait_n), 64'd1);
    if (mem_req !== 1'b1) return;
    for (int i = 0; i <= alat; i++) begin
      if (i > 0) @(negedge clk);
      chk("req_mem_req", 64'(mem_req), 64'd1);
      chk("req_fields", {mem_wr, mem_wstrb, mem_addr}, {e_wr, e_strb, e_addr});
      chk("req_wdata", 64'(mem_wdata), 64'(e_wdata));
      chk("req_no_pulse", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0000);
    end
    mem_addr_ok = 1'b1;
    #1;
    chk("addr_ok_owner", {inst_addr_ok, data_addr_ok}, exp_data ? 2'b01 : 2'b10);
    @(negedge clk);
    mem_addr_ok = 1'b0;
    #1;
    chk("wait_mem_req", 64'(mem_req), 64'd0);
    for (int i = 0; i < dlat; i++) begin
      chk("wait_no_pulse", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0000);
      @(negedge clk);
    end
    mem_data_ok = 1'b1;
    mem_rdata   = rdata;
    #1;
    chk("data_ok_owner", {inst_data_ok, data_data_ok}, exp_data ? 2'b01 : 2'b10);
    chk("rdata", 64'(exp_data ? data_rdata : inst_rdata), 64'(rdata));
    @(negedge clk);
    mem_data_ok = 1'b0;
  endtask

  initial begin
    int wait_n;
    bit e;
    resetn = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    inst_req = 1'b1; inst_addr = 32'h1c00_0000;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h1c00_0100; data_wdata = 32'h0;

    // T1 reset with both requests pending, data wins first
    repeat (3) @(negedge clk);
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0000);
    resetn = 1'b1;
    serve(1'b1, 1, 1, 32'h0bad_0001);
    data_req = 1'b0;
    serve(1'b0, 0, 0, 32'h1111_2222);
    inst_req = 1'b0;

    // T2 single load
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h1c00_0100;
    serve(1'b1, 2, 3, 32'hdead_beef);
    data_req = 1'b0;

    // T3 store
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011; data_addr = 32'h1c00_0200;
    data_wdata = 32'h1234_5678;
    serve(1'b1, 1, 1, $urandom);
    data_req = 1'b0;

    // T5 address-phase stall on a fetch
    inst_req = 1'b1; inst_addr = 32'h1c00_0040;
    serve(1'b0, 10, 2, $urandom);
    inst_req = 1'b0;

    // T4 sustained contention: every fifth grant goes to fetch
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0;
    for (int k = 0; k < 12; k++) begin
      serve((k % (LIMIT + 1)) != LIMIT, $urandom_range(0, 2), $urandom_range(0, 2), $urandom);
    end
    inst_req = 1'b0; data_req = 1'b0;

    // T6 asynchronous reset while waiting for data
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1c00_0300;
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (mem_req !== 1'b1 && wait_n < 8);
    chk("t6_grant", 64'(mem_req), 64'd1);
    mem_addr_ok = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b0;
    #2;
    mem_data_ok = 1'b1;
    resetn = 1'b0;
    #1;
    chk("t6_reset_outputs", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 5'b00000);
    @(negedge clk);
    mem_data_ok = 1'b0; data_req = 1'b0; resetn = 1'b1; starve_m = 0;
    inst_req = 1'b1; inst_addr = 32'h1c00_0080;
    serve(1'b0, 1, 1, $urandom);

    // Randomized traffic against the arbitration model
    inst_req = 1'b0;
    rand_data();
    data_req = 1'b1;
    for (int n = 0; n < 40; n++) begin
      e = predict_data();
      serve(e, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if (e) begin
        data_req = 1'($urandom_range(0, 1));
        if (data_req) rand_data();
        if (!inst_req) begin
          inst_req = 1'($urandom_range(0, 1));
          if (inst_req) rand_inst();
        end
      end else begin
        inst_req = 1'($urandom_range(0, 1));
        if (inst_req) rand_inst();
        if (!data_req) begin
          data_req = 1'($urandom_range(0, 1));
          if (data_req) rand_data();
        end
      end
      if (!inst_req && !data_req) begin
        if ($urandom_range(0, 1) == 1) begin
          data_req = 1'b1; rand_data();
        end else begin
          inst_req = 1'b1; rand_inst();
        end
      end
    end
    inst_req = 1'b0; data_req = 1'b0;

    repeat (4) @(negedge clk);
    chk("idle_mem_req", 64'(mem_req), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
